cpu5_dmem_resp: RTL and testbench

Data-memory responder that serves the load/store requests issued by the cpu5 core datapath. It accepts one request at a time over a valid/ready channel and holds a word-addressed register array with byte-enable writes. A programmable wait-state counter delays each response, so the core's memory interface can be tested against a multi-cycle memory. Sits between the core's data port and the testbench/SoC fabric.

---
 rtl/cpu5_dmem_resp.sv | 184 ++++++++++++++++++
 tb/tb_cpu5_dmem_resp.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu5_dmem_resp.sv
// cpu5_dmem_resp
//   Data-memory responder for the cpu5 core data port. Accepts one load or
//   store at a time, delays it by LATENCY wait cycles, commits it to a
//   word-addressed array with byte enables, then holds the response until
//   the consumer takes it.
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous active-low reset
//     req_valid  request present            req_ready  responder idle
//     req_we     1 = store, 0 = load        req_addr   byte address
//     req_wdata  store data                 req_be     store byte enables
//     rsp_valid  response present           rsp_ready  consumer accepts
//     rsp_rdata  load data (0 for stores)   rsp_err    misaligned access
//
//   Optional feature
//     CPU5_DMEM_MISALIGN_EN : when defined, a request with req_addr[1:0] != 0
//     is timed normally but writes nothing, reads back 0 and raises rsp_err.
//     When undefined, req_addr[1:0] is ignored and rsp_err is tied to 0.
//
//   All outputs come from registers or from the state register; no req_*
//   input reaches an output combinationally.
module cpu5_dmem_resp #(
   parameter int XLEN    = 32,
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [3:0]      req_be,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Everything the commit needs, captured at acceptance.
   typedef struct packed {
      logic            we;
      logic [AW-1:0]   idx;
      logic [XLEN-1:0] wdata;
      logic [3:0]      be;
      logic            mis;
   } req_t;

   state_t          st, st_n;
   logic [3:0]      cnt, cnt_n;
   req_t            lat, req_in, cmt;
   logic            commit;
   logic            accept;
   logic [XLEN-1:0] mem [DEPTH];
   logic [XLEN-1:0] rdata_q;

   // Address bits outside the word index only matter for the misalign check.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_addr[XLEN-1:AW+2], req_addr[1:0]};

   always_comb begin
      req_in       = '0;
      req_in.we    = req_we;
      req_in.idx   = req_addr[AW+1:2];
      req_in.wdata = req_wdata;
      req_in.be    = req_be;
`ifdef CPU5_DMEM_MISALIGN_EN
      req_in.mis   = (req_addr[1:0] != 2'b00);
`else
      req_in.mis   = 1'b0;
`endif
   end

   assign accept = (st == IDLE) && req_valid;

   // Next state. Commit happens on the edge that enters RESP; with zero
   // latency that is the acceptance edge itself, so the live request is
   // committed directly instead of the (not yet loaded) latch.
   always_comb begin
      st_n   = st;
      cnt_n  = cnt;
      commit = 1'b0;
      cmt    = lat;
      case (st)
         IDLE: begin
            if (req_valid) begin
               if (LATENCY == 0) begin
                  st_n   = RESP;
                  commit = 1'b1;
                  cmt    = req_in;
               end else begin
                  st_n  = WAIT;
                  cnt_n = LATENCY[3:0];
               end
            end
         end
         WAIT: begin
            cnt_n = cnt - 4'd1;
            if (cnt == 4'd1) begin
               st_n   = RESP;
               commit = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) st_n = IDLE;
         end
         default: st_n = IDLE;
      endcase
   end

   function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old,
                                              input logic [XLEN-1:0] wd,
                                              input logic [3:0]      be);
      logic [XLEN-1:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st  <= IDLE;
         cnt <= 4'd0;
         lat <= '0;
      end else begin
         st  <= st_n;
         cnt <= cnt_n;
         if (accept) lat <= req_in;
      end
   end

   // Reset wipes the array so a store cut short by reset leaves no trace.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (commit && cmt.we && !cmt.mis) begin
         mem[cmt.idx] <= merge(mem[cmt.idx], cmt.wdata, cmt.be);
      end
   end

   // Load data is sampled on the commit edge, so it reflects every earlier
   // store and stays frozen through backpressure.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (commit) begin
         rdata_q <= (cmt.we || cmt.mis) ? '0 : mem[cmt.idx];
      end else if (st == RESP && rsp_ready) begin
         rdata_q <= '0;
      end
   end

`ifdef CPU5_DMEM_MISALIGN_EN
   logic err_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (commit) begin
         err_q <= cmt.mis;
      end else if (st == RESP && rsp_ready) begin
         err_q <= 1'b0;
      end
   end
   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign req_ready = (st == IDLE);
   assign rsp_valid = (st == RESP);
   assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_cpu5_dmem_resp.sv
// Bench for cpu5_dmem_resp: directed scenarios followed by randomized
// transactions, all checked against a word-array model of the memory and a
// cycle-count model of the response timing.
module tb_cpu5_dmem_resp;

   localparam int XLEN  = 32;
   localparam int DEPTH = 64;
   localparam int LAT   = 2;
`ifdef CPU5_DMEM_MISALIGN_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic [3:0]      req_be;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_rdata;
   logic            rsp_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_m [DEPTH];

   cpu5_dmem_resp #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
   endtask

   // One full transaction. Entered and left just after a falling edge.
   task automatic do_req(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int hold);
      int          idx;
      bit          mis;
      logic [31:0] exp_rd;
      logic [31:0] w;
      idx = int'((addr >> 2) % DEPTH);
      mis = MIS && (addr[1:0] != 2'b00);
      if (we) begin
         exp_rd = 32'h0;
         if (!mis) begin
            w = mem_m[idx];
            for (int b = 0; b < 4; b++)
               if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            mem_m[idx] = w;
         end
      end else begin
         exp_rd = mis ? 32'h0 : mem_m[idx];
      end

      chk("idle_ready", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      rsp_ready = 1'($urandom);
      @(posedge clk);                       // acceptance edge
      for (int k = 0; k < LAT; k++) begin
         @(negedge clk);
         chk("wait_valid", {31'b0, rsp_valid}, 32'd0);
         chk("wait_ready", {31'b0, req_ready}, 32'd0);
         // Anything on the request side now must be ignored.
         req_valid = 1'($urandom);
         req_we    = 1'($urandom);
         req_addr  = $urandom;
         req_wdata = $urandom;
         req_be    = 4'($urandom);
         rsp_ready = 1'($urandom);
         @(posedge clk);
      end
      @(negedge clk);
      req_valid = 1'b0;
      chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rsp_ready_out", {31'b0, req_ready}, 32'd0);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, mis});
      for (int k = 0; k < hold; k++) begin
         rsp_ready = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
         chk("hold_rdata", rsp_rdata, exp_rd);
         chk("hold_err", {31'b0, rsp_err}, {31'b0, mis});
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("done_valid", {31'b0, rsp_valid}, 32'd0);
      chk("done_ready", {31'b0, req_ready}, 32'd1);
      chk("done_rdata", rsp_rdata, 32'h0);
      chk("done_err", {31'b0, rsp_err}, 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      reset     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      rsp_ready = 1'b0;
      model_clear();
      #1;
      chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err", {31'b0, rsp_err}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Reset in the middle of a store's wait period drops the store.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h10;
      req_wdata = 32'hDEADBEEF;
      req_be    = 4'hF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_wait_ready", {31'b0, req_ready}, 32'd0);
      reset = 1'b0;
      #1;
      chk("async_rst_valid", {31'b0, rsp_valid}, 32'd0);
      chk("async_rst_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      model_clear();
      @(negedge clk);
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);

      // Misaligned store to word 8, then read the aligned word back.
      do_req(1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, 0);
      do_req(1'b0, 32'h20, 32'h0, 4'h0, 0);
      chk("misalign_model_word8", mem_m[8], MIS ? 32'h0 : 32'hFFFFFFFF);
      do_req(1'b0, 32'h22, 32'h0, 4'h0, 1);

      // Preload then timed load.
      do_req(1'b1, 32'h0C, 32'h12345678, 4'hF, 0);
      do_req(1'b0, 32'h0C, 32'h0, 4'h0, 0);

      // Partial byte enables.
      do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 0);
      do_req(1'b1, 32'h20, 32'h11223344, 4'b0101, 0);
      chk("be_model", mem_m[8], 32'hAA22CC44);
      do_req(1'b0, 32'h20, 32'h0, 4'h0, 0);

      // Zero byte enables still respond but write nothing.
      do_req(1'b1, 32'h20, 32'h55555555, 4'b0000, 0);
      do_req(1'b0, 32'h20, 32'h0, 4'h0, 0);

      // Five cycles of backpressure, next request right after handshake.
      do_req(1'b0, 32'h0C, 32'h0, 4'h0, 5);
      do_req(1'b0, 32'h20, 32'h0, 4'h0, 0);

      // Address aliasing modulo DEPTH*4.
      do_req(1'b1, 32'h104, 32'hCAFEF00D, 4'hF, 0);
      do_req(1'b0, 32'h004, 32'h0, 4'h0, 0);
      chk("wrap_model", mem_m[1], 32'hCAFEF00D);

      for (int n = 0; n < 60; n++) begin
         a = $urandom_range(0, 1023);
         if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
         do_req(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
      end

      // Sweep back over every word to catch stray writes.
      for (int i = 0; i < DEPTH; i++)
         do_req(1'b0, 32'(i * 4), 32'h0, 4'h0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
